// File: rtl/instr_loader.sv
// instr_loader: serial byte-stream boot loader for an instruction memory.
//
// A start pulse opens a session that collects min(word_count, DEPTH) 32-bit
// words from an 8-bit valid/ready stream (big-endian, first byte -> [31:24])
// and writes each to consecutive word addresses from BASE_ADDR. busy is high
// for the whole session so the CPU can be held stalled; done pulses once at
// the end.
//
// Optional feature (macro LOADER_CHECKSUM_EN): after the last word one extra
// byte is accepted and compared with the modulo-256 sum of all data bytes;
// a mismatch sets the sticky err flag. Without the macro, err is tied to 0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, word_count    session start pulse, word count (sampled on start)
//   in_valid, in_data    byte stream in
//   in_ready             byte stream ready
//   imem_we/addr/wdata   instruction memory write port (byte address)
//   busy, done, err      session status
module instr_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] FINISH  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK   = 3'd4;
`endif

  // word_count is 6 bits, so a DEPTH above 63 can never clamp.
  localparam logic [5:0] DEPTH_C = (DEPTH > 63) ? 6'd63 : 6'(DEPTH);

  logic [2:0]  state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [5:0]  widx_q,  widx_d;
  logic [1:0]  bidx_q,  bidx_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  clamp;

  assign clamp = (word_count > DEPTH_C) ? DEPTH_C : word_count;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = clamp;
          widx_d  = '0;
          bidx_d  = '0;
          state_d = (clamp == 6'd0) ? FINISH : COLLECT;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      COLLECT: begin
        if (in_valid) begin
          shreg_d = {shreg_q[23:0], in_data};
          bidx_d  = bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
          if (bidx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // On the last word the index is left in place so imem_addr never
        // walks past the final written location.
        if (widx_q + 6'd1 == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = FINISH;
`endif
        end else begin
          widx_d  = widx_q + 6'd1;
          state_d = COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (in_valid) begin
          err_d   = (in_data != sum_q);
          state_d = FINISH;
        end
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state_q == COLLECT) || (state_q == CHECK);
  assign err      = err_q;
`else
  assign in_ready = (state_q == COLLECT);
  assign err      = 1'b0;
`endif

  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = BASE_ADDR + {24'd0, widx_q, 2'b00};
  assign imem_wdata = shreg_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;

  instr_loader #(.DEPTH(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [63:0] sb[$];   // {addr, data}

  // Scoreboard monitor: every write is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && imem_we) begin
      logic [63:0] e;
      wr_cnt++;
      last_addr = imem_addr;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h, no write expected", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                   imem_addr, imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic pulse_start(input logic [5:0] wc);
    @(negedge clk); start = 1'b1; word_count = wc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout in_ready=%b expected 1", in_ready);
    end
    in_valid = 1'b1; in_data = b;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!done && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout done=%b expected 1", done);
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string name, input int exp_wr, input int wr0,
                            input int exp_done, input int d0);
    checks++;
    if (wr_cnt - wr0 != exp_wr || done_cnt - d0 != exp_done || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s writes=%0d dones=%0d busy=%b pending=%0d expected writes=%0d dones=%0d busy=0 pending=0",
               name, wr_cnt - wr0, done_cnt - d0, busy, sb.size(), exp_wr, exp_done);
    end
  endtask

  task automatic check_reset_outs(input string name);
    checks++;
    if ({in_ready, imem_we, busy, done, err} !== 5'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL %s rdy=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h expected all zero",
               name, in_ready, imem_we, busy, done, err, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_reset();
    #1 check_reset_outs("reset_values");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outs("after_reset_release");
  endtask

  task automatic test_basic();
    int w0 = wr_cnt, d0 = done_cnt;
    sb.push_back({32'h0, 32'h20080000});
    sb.push_back({32'h4, 32'h200D0050});
    pulse_start(6'd2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy busy=%b expected 1", busy); end
    send_word(32'h20080000);
    send_word(32'h200D0050);
    wait_done();
    check_idle("basic", 2, w0, 1, d0);
  endtask

  task automatic test_zero();
    int w0 = wr_cnt, d0 = done_cnt;
    @(negedge clk); start = 1'b1; word_count = 6'd0;
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done done=%b expected 1", done); end
    @(negedge clk);
    check_idle("zero_count", 0, w0, 1, d0);
  endtask

  task automatic test_clamp();
    int w0 = wr_cnt, d0 = done_cnt;
    logic [31:0] w;
    pulse_start(6'd40);
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      sb.push_back({32'(i * 4), w});
      send_word(w);
    end
    wait_done();
    check_idle("clamp_40", 32, w0, 1, d0);
    checks++;
    if (last_addr !== 32'h7C) begin errors++; $display("FAIL clamp_last_addr got %h expected 0000007c", last_addr); end
  endtask

  task automatic test_gap();
    int w0 = wr_cnt, d0 = done_cnt;
    sb.push_back({32'h0, 32'hA1B2C3D4});
    pulse_start(6'd1);
    send_byte(8'hA1); send_byte(8'hB2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b0) begin errors++; $display("FAIL gap_we cycle %0d we=%b expected 0", i, imem_we); end
    end
    send_byte(8'hC3); send_byte(8'hD4);
    wait_done();
    check_idle("gap", 1, w0, 1, d0);
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt, d0 = done_cnt;
    sb.push_back({32'h0, 32'h11223344});
    pulse_start(6'd2);
    send_word(32'h11223344);
    send_byte(8'h55); send_byte(8'h66);
    @(negedge clk); rst_n = 1'b0;
    #1 check_reset_outs("mid_reset_outs");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("mid_reset", 1, w0, 0, d0);
    w0 = wr_cnt; d0 = done_cnt;
    sb.push_back({32'h0, 32'hCAFEF00D});
    pulse_start(6'd1);
    send_word(32'hCAFEF00D);
    wait_done();
    check_idle("after_mid_reset", 1, w0, 1, d0);
  endtask

  task automatic test_start_busy();
    int w0 = wr_cnt, d0 = done_cnt;
    sb.push_back({32'h0, 32'h01234567});
    sb.push_back({32'h4, 32'h89ABCDEF});
    pulse_start(6'd2);
    send_byte(8'h01); send_byte(8'h23);
    pulse_start(6'd1);
    send_byte(8'h45); send_byte(8'h67);
    send_word(32'h89ABCDEF);
    wait_done();
    check_idle("start_busy", 2, w0, 1, d0);
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt, d0 = done_cnt;
    for (int s = 0; s < 2; s++) begin
      sb.push_back({32'h0, 32'(32'hDEAD0000 + s)});
      pulse_start(6'd1);
      send_word(32'(32'hDEAD0000 + s));
      wait_done();
    end
    check_idle("back_to_back", 2, w0, 2, d0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_flag err=%b expected 0", err); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] ck[2] = '{8'h0A, 8'h0B};
    for (int k = 0; k < 2; k++) begin
      int d0 = done_cnt;
      sb.push_back({32'h0, 32'h01020304});
      pulse_start(6'd1);
      send_word(32'h01020304);
      send_byte(ck[k]);
      wait_done();
      checks++;
      if (err !== 1'(k) || done_cnt - d0 != 1) begin
        errors++;
        $display("FAIL checksum_%0h err=%b dones=%0d expected err=%0d dones=1", ck[k], err, done_cnt - d0, k);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_clamp();
    test_gap();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter: DEPTH, 32, instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter: BASE_ADDR, 32'h0, byte address of the first word written.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  one-cycle pulse that begins a load session.
REQ-006 SHALL have port: word_count  input  6  number of words to load; sampled on start.
REQ-007 SHALL have port: in_valid  input  1  byte-stream valid.
REQ-008 SHALL have port: in_data  input  8  byte-stream data.
REQ-009 SHALL have port: in_ready  output  1  loader accepts a byte when in_valid and in_ready are both high.
REQ-010 SHALL have port: imem_we  output  1  instruction memory write strobe.
REQ-011 SHALL have port: imem_addr  output  32  byte address; word index = imem_addr>>2.
REQ-012 SHALL have port: imem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have port: busy  output  1  high while a session is active; holds the CPU stalled.
REQ-014 SHALL have port: done  output  1  one-cycle pulse at session end.
REQ-015 SHALL have port: err  output  1  sticky error flag, cleared by next start.

Function
REQ-016 SHALL implement states IDLE, COLLECT, WRITE, FINISH (plus CHECK when configured).
REQ-017 IDLE: start=1 -> COLLECT; latch count = min(word_count, DEPTH); byte index=0; word index=0; err=0.
REQ-018 start with word_count=0 -> FINISH directly; no writes; done pulses the next cycle.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 COLLECT: in_ready=1; each accepted byte shifts in big-endian (first byte -> bits 31:24).
REQ-021 Acceptance of the 4th byte -> WRITE on the next edge.
REQ-022 WRITE: lasts exactly one cycle; imem_we=1; in_ready=0; imem_addr=BASE_ADDR+4*word index; imem_wdata=assembled word.
REQ-023 After WRITE: word index+1; if words written = count -> FINISH (or CHECK); else -> COLLECT.
REQ-024 FINISH: done=1 for one cycle -> IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 imem_we SHALL be 0 outside WRITE; imem_addr never exceeds BASE_ADDR+4*(DEPTH-1).
REQ-027 in_valid gaps SHALL stall COLLECT with no loss of partial-word bytes.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, err=0.
REQ-029 Reset mid-session SHALL discard partial words; words already written stay in memory; no done pulse is issued.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: keep an 8-bit modulo-256 sum of all data bytes; after the last WRITE enter CHECK (in_ready=1), accept one byte, set err=1 if it differs from the sum, then go to FINISH.
REQ-031 Macro LOADER_CHECKSUM_EN undefined: no CHECK state and no sum logic; err is tied to 0.

Verification
REQ-032 start, word_count=2, bytes 20 08 00 00 20 0D 00 50 -> writes (addr 0x0, 0x20080000), (addr 0x4, 0x200D0050); done pulse once.
REQ-033 word_count=40 with DEPTH=32 -> exactly 32 writes; last at addr 0x7C.
REQ-034 in_valid deasserted 5 cycles between bytes 2 and 3 -> same word written; imem_we stays 0 during the gap.
REQ-035 rst_n low after 6 bytes of a 2-word load -> one write only; all outputs at reset values; a new start writes again from addr 0x0.
REQ-036 With LOADER_CHECKSUM_EN, 1 word 01 02 03 04: checksum 0x0A -> err=0; checksum 0x0B -> err=1, done still pulses.
REQ-037 start asserted during COLLECT -> ignored; count and address sequence unchanged.
